// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoding definitions: op enum, opcodes, funct fields, NOP word,
// loader FSM states and the B/J immediate scramblers.
package rv_enc_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLL  = 5'd2,  OP_SRL  = 5'd3,
    OP_OR   = 5'd4,  OP_AND  = 5'd5,  OP_XOR  = 5'd6,  OP_SRA  = 5'd7,
    OP_ADDI = 5'd8,  OP_ANDI = 5'd9,  OP_ORI  = 5'd10, OP_XORI = 5'd11,
    OP_SLLI = 5'd12, OP_SRLI = 5'd13, OP_SRAI = 5'd14, OP_LW   = 5'd15,
    OP_SW   = 5'd16, OP_BEQ  = 5'd17, OP_BNE  = 5'd18, OP_BLT  = 5'd19,
    OP_BGE  = 5'd20, OP_LUI  = 5'd21, OP_JAL  = 5'd22, OP_JALR = 5'd23
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} ld_state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  function automatic logic [31:0] enc_b(logic [31:0] imm, logic [4:0] rs2,
                                        logic [4:0] rs1, logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(logic [31:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

endpackage

// File: rtl/rv_instr_encode.sv
// Combinational RV32I encoder: builds the instruction word from op + fields and
// flags bundles whose op or immediate cannot be represented.
module rv_instr_encode
  import rv_enc_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic imm12_ok, imm13_ok, imm21_ok, shamt_ok, lui_ok;

  // Sign-extension checks: every bit above the field must equal the field's sign bit.
  assign imm12_ok = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
  assign imm13_ok = !imm_i[0] && ((imm_i[31:12] == '0) || (imm_i[31:12] == '1));
  assign imm21_ok = !imm_i[0] && ((imm_i[31:20] == '0) || (imm_i[31:20] == '1));
  assign shamt_ok = (imm_i[31:5] == '0);
  assign lui_ok   = (imm_i[31:20] == '0);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD:  word_o = {F7_BASE, rs2_i, rs1_i, F3_ADD, rd_i, OPC_OP};
      OP_SUB:  word_o = {F7_ALT,  rs2_i, rs1_i, F3_ADD, rd_i, OPC_OP};
      OP_SLL:  word_o = {F7_BASE, rs2_i, rs1_i, F3_SLL, rd_i, OPC_OP};
      OP_SRL:  word_o = {F7_BASE, rs2_i, rs1_i, F3_SR,  rd_i, OPC_OP};
      OP_OR:   word_o = {F7_BASE, rs2_i, rs1_i, F3_OR,  rd_i, OPC_OP};
      OP_AND:  word_o = {F7_BASE, rs2_i, rs1_i, F3_AND, rd_i, OPC_OP};
      OP_XOR:  word_o = {F7_BASE, rs2_i, rs1_i, F3_XOR, rd_i, OPC_OP};
      OP_SRA:  word_o = {F7_ALT,  rs2_i, rs1_i, F3_SR,  rd_i, OPC_OP};
      OP_ADDI: begin word_o = {imm_i[11:0], rs1_i, F3_ADD, rd_i, OPC_OP_IMM}; illegal_o = !imm12_ok; end
      OP_ANDI: begin word_o = {imm_i[11:0], rs1_i, F3_AND, rd_i, OPC_OP_IMM}; illegal_o = !imm12_ok; end
      OP_ORI:  begin word_o = {imm_i[11:0], rs1_i, F3_OR,  rd_i, OPC_OP_IMM}; illegal_o = !imm12_ok; end
      OP_XORI: begin word_o = {imm_i[11:0], rs1_i, F3_XOR, rd_i, OPC_OP_IMM}; illegal_o = !imm12_ok; end
      OP_SLLI: begin word_o = {F7_BASE, imm_i[4:0], rs1_i, F3_SLL, rd_i, OPC_OP_IMM}; illegal_o = !shamt_ok; end
      OP_SRLI: begin word_o = {F7_BASE, imm_i[4:0], rs1_i, F3_SR,  rd_i, OPC_OP_IMM}; illegal_o = !shamt_ok; end
      OP_SRAI: begin word_o = {F7_ALT,  imm_i[4:0], rs1_i, F3_SR,  rd_i, OPC_OP_IMM}; illegal_o = !shamt_ok; end
      OP_LW:   begin word_o = {imm_i[11:0], rs1_i, F3_WORD, rd_i, OPC_LOAD}; illegal_o = !imm12_ok; end
      OP_SW:   begin
        word_o    = {imm_i[11:5], rs2_i, rs1_i, F3_WORD, imm_i[4:0], OPC_STORE};
        illegal_o = !imm12_ok;
      end
      OP_BEQ:  begin word_o = enc_b(imm_i, rs2_i, rs1_i, F3_BEQ); illegal_o = !imm13_ok; end
      OP_BNE:  begin word_o = enc_b(imm_i, rs2_i, rs1_i, F3_BNE); illegal_o = !imm13_ok; end
      OP_BLT:  begin word_o = enc_b(imm_i, rs2_i, rs1_i, F3_BLT); illegal_o = !imm13_ok; end
      OP_BGE:  begin word_o = enc_b(imm_i, rs2_i, rs1_i, F3_BGE); illegal_o = !imm13_ok; end
      OP_LUI:  begin word_o = {imm_i[19:0], rd_i, OPC_LUI}; illegal_o = !lui_ok; end
      OP_JAL:  begin word_o = enc_j(imm_i, rd_i); illegal_o = !imm21_ok; end
      OP_JALR: begin word_o = {imm_i[11:0], rs1_i, F3_ADD, rd_i, OPC_JALR}; illegal_o = !imm12_ok; end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imem_prog_encoder.sv
// Program loader: encodes instruction bundles and streams them into IMEM through a
// 2-entry buffer while holding the CPU in reset. NOP_PAD_EN fills the tail with NOPs.
module imem_prog_encoder
  import rv_enc_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_gnt,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  ld_state_e         state_q;
  logic [ADDR_W:0]   pushed_q;
  logic [31:0]       word_q [2];
  logic [ADDR_W-1:0] addr_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;
  logic              err_q;

  logic [31:0] enc_word, push_word;
  logic        enc_illegal, accept, push, pop, full, mem_full, bad_bundle, drain_ok;

  rv_instr_encode u_enc (
    .op_i      (in_op),
    .rd_i      (in_rd),
    .rs1_i     (in_rs1),
    .rs2_i     (in_rs2),
    .imm_i     (in_imm),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  assign full       = (count_q == 2'd2);
  assign mem_full   = pushed_q[ADDR_W];  // counter saturates at 2^ADDR_W
  assign accept     = in_valid && in_ready;
  assign pop        = (count_q != 2'd0) && imem_gnt;
  assign bad_bundle = enc_illegal || mem_full;

  always_comb begin
    push      = accept && !bad_bundle;
    push_word = enc_word;
`ifdef NOP_PAD_EN
    if (state_q == S_DRAIN && !mem_full && (!full || pop)) begin
      push      = 1'b1;
      push_word = NOP_WORD;
    end
`endif
  end

`ifdef NOP_PAD_EN
  assign drain_ok = mem_full;
`else
  assign drain_ok = 1'b1;
`endif

  assign count_d = count_q + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pushed_q <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      err_q    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        word_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      if (push) begin
        word_q[wr_ptr_q] <= push_word;
        addr_q[wr_ptr_q] <= pushed_q[ADDR_W-1:0];
        wr_ptr_q         <= ~wr_ptr_q;
        pushed_q         <= pushed_q + (ADDR_W+1)'(1);
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q  <= S_LOAD;
            pushed_q <= '0;
            err_q    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept && bad_bundle) err_q <= 1'b1;
          if (accept && in_last) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (count_d == 2'd0 && drain_ok) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == S_LOAD) && !full;
  assign imem_we    = (count_q != 2'd0);
  assign imem_addr  = addr_q[rd_ptr_q];
  assign imem_wdata = word_q[rd_ptr_q];
  assign cpu_hold   = (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_imem_prog_encoder.sv
// Directed bench for imem_prog_encoder: a default-size instance and an ADDR_W=2
// instance share the bundle fields; an IMEM model logs every granted write.
module tb_imem_prog_encoder;
  import rv_enc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start0, start1, in_valid, in_last, imem_gnt, sel;
  logic [4:0]  in_op, in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        v0, v1;
  assign v0 = in_valid && !sel;
  assign v1 = in_valid && sel;

  logic        rdy0, we0, hold0, done0, err0;
  logic [7:0]  a0;
  logic [31:0] wd0;
  logic        rdy1, we1, hold1, done1, err1;
  logic [1:0]  a1;
  logic [31:0] wd1;

  imem_prog_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start0), .in_valid(v0), .in_ready(rdy0),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_last(in_last), .imem_we(we0), .imem_gnt(imem_gnt), .imem_addr(a0),
    .imem_wdata(wd0), .cpu_hold(hold0), .done(done0), .err(err0)
  );

  imem_prog_encoder #(.ADDR_W(2)) dut_small (
    .clk(clk), .rst(rst), .start(start1), .in_valid(v1), .in_ready(rdy1),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_last(in_last), .imem_we(we1), .imem_gnt(imem_gnt), .imem_addr(a1),
    .imem_wdata(wd1), .cpu_hold(hold1), .done(done1), .err(err1)
  );

  logic [31:0] wq0[$], wq1[$];
  logic [7:0]  wa0[$];
  logic [1:0]  wa1[$];

  always @(posedge clk) begin
    if (we0 && imem_gnt) begin
      wq0.push_back(wd0);
      wa0.push_back(a0);
      $display("IMEM0 write addr=%0d data=%h", a0, wd0);
    end
    if (we1 && imem_gnt) begin
      wq1.push_back(wd1);
      wa1.push_back(a1);
      $display("IMEM1 write addr=%0d data=%h", a1, wd1);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_n0(input int n);
`ifdef NOP_PAD_EN
    return 256;
`else
    return n;
`endif
  endfunction

  task automatic pulse_start();
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic last);
    int c = 0;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    while (!(sel ? rdy1 : rdy0) && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (!(sel ? rdy1 : rdy0)) check("accept_timeout", 32'(sel ? rdy1 : rdy0), 32'd1);
    else begin
      @(posedge clk);
      @(negedge clk);
    end
    $display("sent op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h last=%0b", op, rd, rs1, rs2, imm, last);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int c = 0;
    while ((sel ? done1 : done0) !== 1'b1 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("done", 32'(sel ? done1 : done0), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    imem_gnt = 1'b1; sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(rdy0), 32'd0);
    check("rst_imem_we", 32'(we0), 32'd0);
    check("rst_imem_addr", 32'(a0), 32'd0);
    check("rst_imem_wdata", wd0, 32'd0);
    check("rst_cpu_hold", 32'(hold0), 32'd1);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single ADDI session
    base = wq0.size();
    pulse_start();
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    wait_done();
    check("t1_word0", wq0[base], 32'h0050_0093);
    check("t1_addr0", 32'(wa0[base]), 32'd0);
    check("t1_nwrites", 32'(wq0.size() - base), 32'(exp_n0(1)));
    check("t1_cpu_hold", 32'(hold0), 32'd0);
    check("t1_err", 32'(err0), 32'd0);

    // R/S/B/J formats; a stray start mid-LOAD must not disturb addressing
    base = wq0.size();
    pulse_start();
    check("t2_hold_on_restart", 32'(hold0), 32'd1);
    check("t2_done_cleared", 32'(done0), 32'd0);
    send(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    send(OP_SW, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    pulse_start();
    send(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    send(OP_JAL, 5'd1, 5'd0, 5'd0, 32'd16, 1'b1);
    wait_done();
    check("t2_add", wq0[base], 32'h0020_81B3);
    check("t2_sw", wq0[base+1], 32'h0020_A423);
    check("t2_beq", wq0[base+2], 32'h0020_8463);
    check("t2_jal", wq0[base+3], 32'h0100_00EF);
    check("t2_addr3", 32'(wa0[base+3]), 32'd3);

    // backpressure: buffer fills after two accepts
    base = wq0.size();
    imem_gnt = 1'b0;
    pulse_start();
    send(OP_LUI, 5'd5, 5'd0, 5'd0, 32'h0001_2345, 1'b0);
    send(OP_SRAI, 5'd4, 5'd4, 5'd0, 32'd3, 1'b0);
    check("t3_ready_full", 32'(rdy0), 32'd0);
    check("t3_we_full", 32'(we0), 32'd1);
    check("t3_head_word", wd0, 32'h1234_52B7);
    repeat (5) @(negedge clk);
    check("t3_no_write_wo_gnt", 32'(wq0.size() - base), 32'd0);
    imem_gnt = 1'b1;
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 1'b1);
    wait_done();
    check("t3_lui", wq0[base], 32'h1234_52B7);
    check("t3_srai", wq0[base+1], 32'h4032_5213);
    check("t3_addi", wq0[base+2], 32'h0010_0093);
    check("t3_addr1", 32'(wa0[base+1]), 32'd1);

    // illegal bundles are dropped without consuming an address
    base = wq0.size();
    pulse_start();
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0);
    send(5'd30, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 1'b1);
    wait_done();
    check("t4_err", 32'(err0), 32'd1);
    check("t4_word0", wq0[base], 32'h0010_0093);
    check("t4_addr0", 32'(wa0[base]), 32'd0);
    check("t4_nwrites", 32'(wq0.size() - base), 32'(exp_n0(1)));

    // immediate range edges, legal and illegal interleaved
    base = wq0.size();
    pulse_start();
    check("t5_err_cleared", 32'(err0), 32'd0);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 1'b0);
    send(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2047, 1'b0);
    send(OP_SLLI, 5'd1, 5'd1, 5'd0, 32'd32, 1'b0);
    send(OP_BLT, 5'd0, 5'd1, 5'd2, 32'hFFFF_F000, 1'b0);
    send(OP_LUI, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 1'b0);
    send(OP_SW, 5'd0, 5'd1, 5'd2, 32'd2048, 1'b0);
    send(OP_JAL, 5'd0, 5'd0, 5'd0, 32'hFFF0_0000, 1'b1);
    wait_done();
    check("t5_err", 32'(err0), 32'd1);
    check("t5_addi_min", wq0[base], 32'h8000_0093);
    check("t5_addi_max", wq0[base+1], 32'h7FF0_0093);
    check("t5_blt_min", wq0[base+2], 32'h8020_C063);
    check("t5_jal_min", wq0[base+3], 32'h8000_006F);
    check("t5_addr3", 32'(wa0[base+3]), 32'd3);
    check("t5_nwrites", 32'(wq0.size() - base), 32'(exp_n0(4)));

    // capacity overflow on the 4-word instance
    sel = 1'b1;
    base = wq1.size();
    pulse_start();
    for (int k = 1; k <= 5; k++) send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'(k), k == 5);
    wait_done();
    for (int i = 0; i < 4; i++) begin
      check("t6_word", wq1[base+i], 32'((i + 1) << 20) | 32'h93);
      check("t6_addr", 32'(wa1[base+i]), 32'(i));
    end
    check("t6_nwrites", 32'(wq1.size() - base), 32'd4);
    check("t6_err", 32'(err1), 32'd1);

    // reset while draining flushes buffered words
    sel = 1'b0;
    base = wq0.size();
    imem_gnt = 1'b0;
    pulse_start();
    send(OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    send(OP_SUB, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    check("t7_we_drain", 32'(we0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t7_we_after_rst", 32'(we0), 32'd0);
    check("t7_hold_after_rst", 32'(hold0), 32'd1);
    check("t7_done_after_rst", 32'(done0), 32'd0);
    imem_gnt = 1'b1;
    @(negedge clk);
    check("t7_idle_ready", 32'(rdy0), 32'd0);
    check("t7_no_writes", 32'(wq0.size() - base), 32'd0);
    pulse_start();
    check("t7_load_ready", 32'(rdy0), 32'd1);

    // tail padding (or its absence) on the 4-word instance
    sel = 1'b1;
    base = wq1.size();
    pulse_start();
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd7, 1'b1);
    wait_done();
    check("t8_word0", wq1[base], 32'h0070_0093);
`ifdef NOP_PAD_EN
    check("t8_nwrites", 32'(wq1.size() - base), 32'd4);
    for (int i = 1; i < 4; i++) begin
      check("t8_pad_word", wq1[base+i], 32'h0000_0013);
      check("t8_pad_addr", 32'(wa1[base+i]), 32'(i));
    end
`else
    check("t8_nwrites", 32'(wq1.size() - base), 32'd1);
`endif
    check("t8_err", 32'(err1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
